muldiv_seq: RTL and testbench

Multi-cycle sequencer for 16-bit multiply and divide, placed beside the single-cycle exe ALU. Accepts one operation per start handshake, iterates a shared shift/add-subtract datapath over 16 cycles, applies sign correction and delivers a 32-bit HI/LO result with a one-cycle done pulse. The pipeline holds on busy until done.

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Start/result bundle between the pipeline and the multi-cycle mul/div unit.
// master: pipeline side (start, flush, op, op_a, op_b); slave: the sequencer.
interface muldiv_seq_if;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        div_zero;

    modport master (
        output start, flush, op, op_a, op_b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, flush, op, op_a, op_b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// 16-bit multi-cycle multiply/divide sequencer (MULTU/MULT/DIVU/DIV).
// Ports: clk, rst (sync, active-high), bus (slave): start/flush/op/op_a/op_b
// in; busy/done/hi/lo/div_zero out. Results in hi/lo after a done pulse.
module muldiv_seq (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic [16:0] sum17;
    logic [16:0] r17;
    logic [16:0] trial;
    logic [31:0] neg_acc;
    logic [15:0] abs_a;
    logic [15:0] abs_b;

    // Signed ops operate on magnitudes; 0x8000 stays 0x8000.
    always_comb begin
        abs_a = (bus.op[0] && bus.op_a[15]) ? (~bus.op_a + 16'd1) : bus.op_a;
        abs_b = (bus.op[0] && bus.op_b[15]) ? (~bus.op_b + 16'd1) : bus.op_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        sum17   = {1'b0, acc_q[31:16]}
                + (acc_q[0] ? {1'b0, mcand_q} : 17'd0);
        r17     = {acc_q[31:16], acc_q[15]};
        trial   = r17 - {1'b0, mcand_q};
        neg_acc = ~acc_q + 32'd1;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    qsign_d = bus.op[0] & (bus.op_a[15] ^ bus.op_b[15]);
                    rsign_d = bus.op[0] & bus.op_a[15];
                    cnt_d   = 4'd0;
                    if (bus.op[1] && bus.op_b == 16'd0) begin
                        hi_d    = bus.op_a;
                        lo_d    = 16'hFFFF;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (bus.op[1]) begin
                        // Low half shifts dividend out, quotient bits in.
                        acc_d   = {16'd0, abs_a};
                        mcand_d = abs_b;
                        state_d = ITER;
                    end else begin
                        // Low half holds the multiplier, consumed LSB first.
                        acc_d   = {16'd0, abs_b};
                        mcand_d = abs_a;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (op_q[1]) begin
                    // Partial remainder < divisor, so the 17-bit
                    // trial sign bit is an exact borrow.
                    if (!trial[16]) begin
                        acc_d = {trial[15:0], acc_q[14:0], 1'b1};
                    end else begin
                        acc_d = {r17[15:0], acc_q[14:0], 1'b0};
                    end
                end else begin
                    acc_d = {sum17, acc_q[15:1]};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = qsign_q ? neg_acc : acc_q;
                end else begin
                    lo_d = qsign_q ? (~acc_q[15:0] + 16'd1)
                                   : acc_q[15:0];
                    hi_d = rsign_q ? (~acc_q[31:16] + 16'd1)
                                   : acc_q[31:16];
                end
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush aborts without touching the visible result registers.
        if (bus.flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = dz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            acc_q   <= 32'd0;
            mcand_q <= 16'd0;
            hi_q    <= 16'd0;
            lo_q    <= 16'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed corner cases plus random ops
// checked against an arithmetic reference of MULT/DIV semantics.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Returns {div_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [32:0] ref_op(input logic [1:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        int sa;
        int sb;
        int q;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'b00: begin
                p = {16'd0, a} * {16'd0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 16'd0) return {1'b1, a, 16'hFFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 16'd0) return {1'b1, a, 16'hFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[15:0], q[15:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input bit hold);
        logic [32:0] exp;
        int cyc;
        int want;
        exp  = ref_op(op, a, b);
        want = (op[1] && b == 16'd0) ? 0 : 17;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = hold;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
        bus.op    = 2'($urandom);
        chk("busy_acc", {31'd0, bus.busy}, 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("latency", cyc, want);
        chk("hi", {16'd0, bus.hi}, {16'd0, exp[31:16]});
        chk("lo", {16'd0, bus.lo}, {16'd0, exp[15:0]});
        chk("dz", {31'd0, bus.div_zero}, {31'd0, exp[32]});
        @(posedge clk);
        #1;
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
        chk("done_end", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [15:0] b;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'd0;
        bus.op_a  = 16'd0;
        bus.op_b  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 32'd0);
        chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;

        run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(2'b01, 16'hFFFD, 16'h0005, 1'b0);
        run_op(2'b01, 16'h8000, 16'h8000, 1'b1);
        run_op(2'b10, 16'd100, 16'd7, 1'b0);
        run_op(2'b11, 16'hFFF9, 16'd2, 1'b0);
        run_op(2'b11, 16'h8000, 16'hFFFF, 1'b0);
        run_op(2'b10, 16'h1234, 16'd0, 1'b0);
        run_op(2'b10, 16'd9, 16'd3, 1'b0);
        run_op(2'b11, 16'h4321, 16'd0, 1'b0);
        run_op(2'b11, 16'd7, 16'hFFFE, 1'b0);

        // Flush mid-iteration: no done, result registers untouched.
        run_op(2'b00, 16'd3, 16'd4, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.op_a  = 16'd50;
        bus.op_b  = 16'd5;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("fl_busy", {31'd0, bus.busy}, 32'd0);
        chk("fl_hilo", {bus.hi, bus.lo}, 32'd12);
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("fl_nodone", dones, 0);
        chk("fl_hilo2", {bus.hi, bus.lo}, 32'd12);

        // Reset at ITER cnt=9.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.op_a  = 16'h1357;
        bus.op_b  = 16'h2468;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_busy", {31'd0, bus.busy}, 32'd0);
        chk("mr_done", {31'd0, bus.done}, 32'd0);
        chk("mr_hilo", {bus.hi, bus.lo}, 32'd0);
        chk("mr_dz", {31'd0, bus.div_zero}, 32'd0);

        // start and flush together: nothing accepted.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("sf_busy", {31'd0, bus.busy}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            run_op(2'($urandom), 16'($urandom), b, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
